// File: rtl/mem_sad_if.sv
// Handshake and memory-port bundle between the MEM stage and the SAD engine.
//   Start/BaseA/BaseB : SAD instruction and operand bases coming from EX/MEM
//   MemAddr/MemReadEn : data-memory read request issued by the engine
//   MemRdData         : read data, valid the cycle after MemReadEn
//   Stall/Done        : pipeline freeze and completion pulse
//   SADResult         : last completed SAD value
interface mem_sad_if;
  logic        Start;
  logic [31:0] BaseA;
  logic [31:0] BaseB;
  logic [31:0] MemAddr;
  logic        MemReadEn;
  logic [31:0] MemRdData;
  logic        Stall;
  logic        Done;
  logic [31:0] SADResult;

  // Pipeline/memory side: drives the instruction and the read data.
  modport master (
    output Start, BaseA, BaseB, MemRdData,
    input  MemAddr, MemReadEn, Stall, Done, SADResult
  );

  // Engine side.
  modport slave (
    input  Start, BaseA, BaseB, MemRdData,
    output MemAddr, MemReadEn, Stall, Done, SADResult
  );
endinterface

// File: rtl/mem_sad_engine.sv
// Multi-cycle MEM-stage SAD unit. Streams N_WORDS words of block A and block B
// through one synchronous read port (A word, then B word, then accumulate) and
// holds the pipeline until the 32-bit sum of byte-wise absolute differences is
// ready.
//   Clk   : clock, all state changes on the rising edge
//   Reset : synchronous, active-high
//   bus   : mem_sad_if slave (instruction, memory read port, stall/done/result)
module mem_sad_engine #(
  parameter int unsigned N_WORDS = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic     Clk,
  input  logic     Reset,
  mem_sad_if.slave bus
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PSUM_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_A,
    FETCH_B,
    ACCUM,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   a_word_q, a_word_d;
  logic [ADDR_W-1:0]   base_a_q, base_a_d;
  logic [ADDR_W-1:0]   base_b_q, base_b_d;
  logic [DATA_W-1:0]   result_q, result_d;

  logic [ADDR_W-1:0]   mem_addr_c;
  logic                mem_re_c;
  logic                stall_c;
  logic                done_c;
  logic [ADDR_W-1:0]   word_off_c;
  logic [DATA_W-1:0]   acc_sum_c;

  // Sum of the four unsigned byte-wise absolute differences of two words.
  function automatic logic [PSUM_W-1:0] word_sad(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    logic [PSUM_W-1:0] s;
    logic [7:0]        ab;
    logic [7:0]        bb;
    s = '0;
    for (int k = 0; k < 4; k++) begin
      ab = a[8*k +: 8];
      bb = b[8*k +: 8];
      s  = s + PSUM_W'((ab > bb) ? (ab - bb) : (bb - ab));
    end
    return s;
  endfunction

  // Byte offset of word i; address adds wrap modulo 2^32.
  assign word_off_c = ADDR_W'({cnt_q, 2'b00});
  assign acc_sum_c  = acc_q + DATA_W'(word_sad(a_word_q, bus.MemRdData));

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    a_word_d   = a_word_q;
    base_a_d   = base_a_q;
    base_b_d   = base_b_q;
    result_d   = result_q;
    mem_addr_c = '0;
    mem_re_c   = 1'b0;
    stall_c    = 1'b0;
    done_c     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          stall_c  = 1'b1;
          base_a_d = bus.BaseA & ~32'h3;
          base_b_d = bus.BaseB & ~32'h3;
          cnt_d    = '0;
          acc_d    = '0;
          state_d  = FETCH_A;
        end
      end
      FETCH_A: begin
        stall_c    = 1'b1;
        mem_re_c   = 1'b1;
        mem_addr_c = base_a_q + word_off_c;
        state_d    = FETCH_B;
      end
      FETCH_B: begin
        // Read data on the port now is the A word requested last cycle.
        stall_c    = 1'b1;
        mem_re_c   = 1'b1;
        mem_addr_c = base_b_q + word_off_c;
        a_word_d   = bus.MemRdData;
        state_d    = ACCUM;
      end
      ACCUM: begin
        stall_c = 1'b1;
        acc_d   = acc_sum_c;
        if (cnt_q == CNT_W'(N_WORDS - 1)) begin
          result_d = acc_sum_c;
          state_d  = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = FETCH_A;
        end
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_word_q <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      a_word_q <= a_word_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      result_q <= result_d;
    end
  end

  assign bus.MemAddr   = mem_addr_c;
  assign bus.MemReadEn = mem_re_c;
  assign bus.Stall     = stall_c;
  assign bus.Done      = done_c;
  assign bus.SADResult = result_q;

endmodule

// File: tb/tb_mem_sad_engine.sv
// Directed bench for mem_sad_engine (N_WORDS=4): table of block pairs with
// hand-computed SAD values, plus reset-abort and back-to-back sequences.
module tb_mem_sad_engine;

  localparam int unsigned NW = 4;

  typedef struct {
    logic [31:0]          a_base;
    logic [31:0]          b_base;
    logic [NW-1:0][31:0]  a_w;
    logic [NW-1:0][31:0]  b_w;
    logic [31:0]          exp;
    bit                   toggle;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [31:0] last_result;
  logic [31:0] mem [0:1023];
  vec_t vecs [5];

  mem_sad_if bus ();

  mem_sad_engine #(.N_WORDS(NW), .CNT_W(8)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port data memory.
  always @(posedge clk) begin
    if (bus.MemReadEn) bus.MemRdData <= mem[bus.MemAddr[11:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Runs one operation starting in the next cycle (cycle 0) and checks
  // stall window, Done timing, read addresses and the result.
  task automatic run_op(input int vi);
    vec_t        v;
    logic [31:0] a_al;
    logic [31:0] b_al;
    logic [31:0] got [$];
    logic [31:0] ea;
    int          stall_cnt;
    int          done_cnt;
    int          done_cyc;
    v         = vecs[vi];
    a_al      = v.a_base & ~32'h3;
    b_al      = v.b_base & ~32'h3;
    stall_cnt = 0;
    done_cnt  = 0;
    done_cyc  = -1;
    for (int i = 0; i < int'(NW); i++) begin
      mem[10'((a_al + 32'(4 * i)) >> 2)] = v.a_w[i];
      mem[10'((b_al + 32'(4 * i)) >> 2)] = v.b_w[i];
    end
    @(negedge clk);
    bus.Start = 1'b1;
    bus.BaseA = v.a_base;
    bus.BaseB = v.b_base;
    #1;
    for (int k = 0; k <= 13; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      if (bus.Stall) stall_cnt++;
      if (bus.Done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (bus.MemReadEn) got.push_back(bus.MemAddr);
      else if (k > 0 && k < 13) chk($sformatf("v%0d idle_addr_c%0d", vi, k), bus.MemAddr, 32'h0);
      if (k == 12) chk($sformatf("v%0d hold", vi), bus.SADResult, last_result);
      // After acceptance, Start/bases may wander; the engine must ignore them.
      if (k >= 1) begin
        bus.Start = v.toggle ? 1'(k % 2) : 1'b0;
        if (v.toggle) begin
          bus.BaseA = 32'hDEAD_0000 + 32'(k);
          bus.BaseB = 32'hBEEF_0000 + 32'(k);
        end
        if (k >= 12) bus.Start = 1'b0;
      end
    end
    chk($sformatf("v%0d stall_cycles", vi), 32'(stall_cnt), 32'd13);
    chk($sformatf("v%0d done_cycle", vi), 32'(done_cyc), 32'd13);
    chk($sformatf("v%0d done_pulses", vi), 32'(done_cnt), 32'd1);
    chk($sformatf("v%0d reads", vi), 32'(got.size()), 32'(2 * NW));
    for (int j = 0; j < int'(2 * NW); j++) begin
      ea = ((j % 2) == 1 ? b_al : a_al) + 32'(4 * (j / 2));
      if (j < got.size()) chk($sformatf("v%0d addr%0d", vi, j), got[j], ea);
    end
    chk($sformatf("v%0d result", vi), bus.SADResult, v.exp);
    last_result = v.exp;
  endtask

  initial begin
    int dcnt;
    checks      = 0;
    failures    = 0;
    last_result = 32'h0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

    // Identical blocks -> 0.
    vecs[0] = '{32'h100, 32'h200,
                {32'hDEADBEEF, 32'h12345678, 32'h00FF7F80, 32'hA5A5A5A5},
                {32'hDEADBEEF, 32'h12345678, 32'h00FF7F80, 32'hA5A5A5A5},
                32'd0, 1'b0};
    // 4 bytes x 255 x 4 words = 4080.
    vecs[1] = '{32'h100, 32'h200,
                {4{32'hFF00FF00}}, {4{32'h00FF00FF}}, 32'h0000_0FF0, 1'b1};
    // Word 0 differs by 3+1+1+3.
    vecs[2] = '{32'h100, 32'h200,
                {32'h55667788, 32'h55667788, 32'h55667788, 32'h01020304},
                {32'h55667788, 32'h55667788, 32'h55667788, 32'h04030201},
                32'd8, 1'b0};
    // Unaligned bases; 4 x 128 per word x 4 words = 2048.
    vecs[3] = '{32'h103, 32'h207,
                {4{32'h80808080}}, {4{32'h00000000}}, 32'd2048, 1'b1};
    // 255 + 255 per word x 4 = 2040.
    vecs[4] = '{32'h300, 32'h340,
                {4{32'h000000FF}}, {4{32'hFF000000}}, 32'd2040, 1'b0};

    bus.Start     = 1'b0;
    bus.BaseA     = 32'h0;
    bus.BaseB     = 32'h0;
    bus.MemRdData = 32'h0;
    rst           = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst stall", 32'(bus.Stall), 32'h0);
    chk("rst done", 32'(bus.Done), 32'h0);
    chk("rst re", 32'(bus.MemReadEn), 32'h0);
    chk("rst addr", bus.MemAddr, 32'h0);
    chk("rst result", bus.SADResult, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("idle stall", 32'(bus.Stall), 32'h0);
    chk("idle re", 32'(bus.MemReadEn), 32'h0);

    for (int i = 0; i < 5; i++) run_op(i);

    // Reset in cycle 5 of an operation aborts it.
    @(negedge clk);
    bus.Start = 1'b1;
    bus.BaseA = 32'h100;
    bus.BaseB = 32'h200;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("abort stall", 32'(bus.Stall), 32'h0);
    chk("abort result", bus.SADResult, 32'h0);
    chk("abort done", 32'(bus.Done), 32'h0);
    rst  = 1'b0;
    dcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.Done) dcnt++;
    end
    chk("abort no_done", 32'(dcnt), 32'h0);
    chk("abort idle_stall", 32'(bus.Stall), 32'h0);
    last_result = 32'h0;
    run_op(2);

    // Back-to-back: 8, then 4080 launched in the IDLE cycle after DONE.
    run_op(2);
    run_op(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
